hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline hazard and stall sequencer for the 5-stage RV32I core. It drives the stage enables and flushes consumed by fetch_cycle (EN1, EN2, FlushD) and the later stage registers. It generates the ALU forwarding selects and sequences multi-cycle data-memory waits, with a watchdog that flags a memory error. It also keeps stall and flush performance counters.

Parameters:
TIMEOUT, 16, max consecutive MEM_WAIT cycles before MemErr; range 2..255
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
Rs1D, Rs2D  in  5  source regs in Decode
Rs1E, Rs2E  in  5  source regs in Execute
RdE, RdM, RdW  in  5  dest regs in E/M/W
MemReadE  in  1  load instruction in Execute
RegWriteM, RegWriteW  in  1  reg write pending in M/W
PCSrcE  in  1  taken branch/jump resolved in Execute
MemReqM  in  1  data-memory access in Memory stage
MemReadyM  in  1  data memory completes access this cycle
ForwardAE, ForwardBE  out  2  00 regfile, 01 from W, 10 from M
EN1  out  1  PC enable (StallF active-low form)
EN2  out  1  IF/ID enable
EN3  out  1  ID/EX enable
EN4  out  1  EX/MEM and MEM/WB enable
FlushD  out  1  clear IF/ID
FlushE  out  1  clear ID/EX
MemErr  out  1  sticky memory-timeout flag
StallCnt  out  CNT_W  cycles with EN1=0
FlushCnt  out  CNT_W  cycles with FlushD=1

Behaviour:
- Single clock and reset: one clock, clk. Reset is synchronous and active-low on rst.
- rst=0 sampled at an edge:
  - state=RUN, wait counter=0, MemErr=0, StallCnt=0, FlushCnt=0.
  - While rst=0, combinational outputs are forced to EN1..EN4=1, FlushD=FlushE=0, ForwardAE=ForwardBE=00.
- Output timing: all EN/Flush/Forward outputs are combinational from current inputs and registered state (zero latency). Counters and MemErr are registered and update one cycle later.
- Forwarding (A shown, B identical with Rs2E):
  - 10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - Else 01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - Else 00.
  - M has priority over W. Forwarding is computed in every state.
- lwStall = MemReadE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- memStall = (state==RUN & MemReqM & !MemReadyM) | (state==MEM_WAIT & !MemReadyM & !timeout).
- Priority, highest first:
  1. memStall: EN1=EN2=EN3=EN4=0, FlushD=FlushE=0. Any pending flush is deferred; PCSrcE stays held in the frozen E stage and takes effect on release.
  2. PCSrcE: FlushD=1, FlushE=1, all EN=1. This also overrides lwStall, because the load-dependent instruction is being flushed.
  3. lwStall: EN1=0, EN2=0, FlushE=1, EN3=EN4=1, FlushD=0.
  4. Otherwise all EN=1, no flush.
- FSM, two states:
  - RUN -> MEM_WAIT when MemReqM & !MemReadyM; the wait counter loads 1.
  - MEM_WAIT, MemReadyM=1: release this cycle (priorities 2-4 apply), -> RUN, counter cleared.
  - MEM_WAIT, MemReadyM=0 and counter<TIMEOUT: stay, counter+1.
  - MEM_WAIT, counter==TIMEOUT (timeout): release the pipeline this cycle, set MemErr=1 (sticky until reset), -> RUN.
- MemReqM dropping while in MEM_WAIT is ignored; only MemReadyM or timeout exits.
- Counters:
  - StallCnt increments each non-reset cycle with EN1=0.
  - FlushCnt increments each cycle with FlushD=1.
  - Both wrap modulo 2^CNT_W.
- Reset mid-MEM_WAIT: the next cycle is RUN with the counter cleared, and the pipeline is not frozen.
- x0 is never a hazard: Rd=0 never forwards and never stalls.

Decomposition:
- Shared package rv32_pipe_pkg:
  - forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - FSM state encoding RUN=1'b0, MEM_WAIT=1'b1.
- Sub-module fwd_unit: purely combinational forwarding compare, instantiated twice (A and B).
- The FSM, stall logic and counters stay in hazard_ctrl.

Test Plan:
- Forwarding:
  - RdM=5, RegWriteM=1, Rs1E=5, plus RdW=5, RegWriteW=1 -> ForwardAE=10.
  - Drop RegWriteM -> ForwardAE=01.
  - RdM=0, Rs1E=0 -> 00.
- Load-use: MemReadE=1, RdE=7, Rs2D=7 for one cycle -> EN1=0, EN2=0, FlushE=1, EN3=1; StallCnt goes 0->1 on the next cycle.
- Branch vs load-use: PCSrcE=1 together with the same lwStall inputs -> FlushD=1, FlushE=1, EN1=EN2=1; FlushCnt +1.
- Memory wait:
  - MemReqM=1, MemReadyM=0 for 3 cycles, then MemReadyM=1 -> EN1..EN4=0 for 3 cycles, all 1 on the 4th; state returns to RUN; StallCnt +3.
  - PCSrcE=1 held during the wait -> flushes only on the release cycle.
- Timeout: TIMEOUT=4, MemReqM=1, MemReadyM=0 held -> frozen for 4 cycles, released on the 5th, MemErr=1 from then. MemErr stays 1 through later traffic and clears only with rst=0.
- Reset mid-wait: assert rst=0 during MEM_WAIT -> outputs at idle values while rst=0; after rst=1, MemReadyM=0 with MemReqM=0 gives no stall; counters and MemErr read 0.

Source files
------------

// File: rtl/rv32_pipe_pkg.sv
// Shared pipeline control types for the rv32 core:
// forward selects, hazard FSM state and stage control bundle.
package rv32_pipe_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic en1;
    logic en2;
    logic en3;
    logic en4;
    logic flushd;
    logic flushe;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_IDLE = '{
    en1: 1'b1,
    en2: 1'b1,
    en3: 1'b1,
    en4: 1'b1,
    flushd: 1'b0,
    flushe: 1'b0
  };

  // x0 is hardwired zero, so a write to it is never a real producer
  function automatic logic fwd_hit(
    input logic       we,
    input logic [4:0] rd,
    input logic [4:0] rs
  );
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// ALU operand forward select for one Execute source register.
// Memory stage result wins over Writeback.
module fwd_unit
  import rv32_pipe_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rdm,
  input  logic [4:0] rdw,
  input  logic       regwritem,
  input  logic       regwritew,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (fwd_hit(regwritem, rdm, rs)) begin
      sel = FWD_M;
    end else if (fwd_hit(regwritew, rdw, rs)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall sequencer: forwarding, load-use and branch flushes,
// data-memory wait FSM with watchdog, stall/flush counters.
module hazard_ctrl
  import rv32_pipe_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             MemReadE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             EN1,
  output logic             EN2,
  output logic             EN3,
  output logic             EN4,
  output logic             FlushD,
  output logic             FlushE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  hz_state_t   state;
  hz_state_t   state_n;
  logic [7:0]  wcnt;
  logic [7:0]  wcnt_n;
  logic        err_set;
  logic        tmo;
  logic        lw_stall;
  logic        mem_stall;
  logic        c_mem;
  logic        c_br;
  logic        c_lw;
  logic [1:0]  fa;
  logic [1:0]  fb;
  stage_ctrl_t ctrl;

  fwd_unit u_fwd_a (
    .rs        (Rs1E),
    .rdm       (RdM),
    .rdw       (RdW),
    .regwritem (RegWriteM),
    .regwritew (RegWriteW),
    .sel       (fa)
  );

  fwd_unit u_fwd_b (
    .rs        (Rs2E),
    .rdm       (RdM),
    .rdw       (RdW),
    .regwritem (RegWriteM),
    .regwritew (RegWriteW),
    .sel       (fb)
  );

  assign tmo = (state == MEM_WAIT) && (wcnt == TMO);

  assign lw_stall = MemReadE && (RdE != 5'd0)
                 && ((RdE == Rs1D) || (RdE == Rs2D));

  assign mem_stall =
      ((state == RUN) && MemReqM && !MemReadyM)
   || ((state == MEM_WAIT) && !MemReadyM && !tmo);

  // one-hot priority terms: freeze > branch flush > load-use
  assign c_mem = mem_stall;
  assign c_br  = !mem_stall && PCSrcE;
  assign c_lw  = !mem_stall && !PCSrcE && lw_stall;

  always_comb begin
    ctrl = CTRL_IDLE;
    if (rst) begin
      unique case (1'b1)
        c_mem: begin
          ctrl.en1 = 1'b0;
          ctrl.en2 = 1'b0;
          ctrl.en3 = 1'b0;
          ctrl.en4 = 1'b0;
        end
        c_br: begin
          ctrl.flushd = 1'b1;
          ctrl.flushe = 1'b1;
        end
        c_lw: begin
          ctrl.en1    = 1'b0;
          ctrl.en2    = 1'b0;
          ctrl.flushe = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign EN1       = ctrl.en1;
  assign EN2       = ctrl.en2;
  assign EN3       = ctrl.en3;
  assign EN4       = ctrl.en4;
  assign FlushD    = ctrl.flushd;
  assign FlushE    = ctrl.flushe;
  assign ForwardAE = rst ? fa : FWD_RF;
  assign ForwardBE = rst ? fb : FWD_RF;

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    err_set = 1'b0;
    unique case (state)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          state_n = MEM_WAIT;
          wcnt_n  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          state_n = RUN;
          wcnt_n  = 8'd0;
        end else if (tmo) begin
          state_n = RUN;
          wcnt_n  = 8'd0;
          err_set = 1'b1;
        end else begin
          wcnt_n  = wcnt + 8'd1;
        end
      end
      default: begin
        state_n = RUN;
        wcnt_n  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= RUN;
      wcnt     <= 8'd0;
      MemErr   <= 1'b0;
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      state  <= state_n;
      wcnt   <= wcnt_n;
      MemErr <= MemErr | err_set;
      if (!ctrl.en1) begin
        StallCnt <= StallCnt + CNT_W'(1);
      end
      if (ctrl.flushd) begin
        FlushCnt <= FlushCnt + CNT_W'(1);
      end
    end
  end

endmodule
